// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: runs the sample BRAM as a circular buffer with a
// programmable pre-trigger depth, controlled over the 16-bit register bus chain.
module la_capture_ctrl #(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int unsigned SAMPLE_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            trig,
    output logic                            bram_we,
    output logic [$clog2(SAMPLE_DEPTH)-1:0] bram_addr,
    output logic                            capture_done,
    input  logic [15:0]                     addr_i,
    input  logic [15:0]                     wdata_i,
    input  logic [15:0]                     rdata_i,
    input  logic                            rw_i,
    input  logic                            valid_i,
    output logic [15:0]                     addr_o,
    output logic [15:0]                     wdata_o,
    output logic [15:0]                     rdata_o,
    output logic                            rw_o,
    output logic                            valid_o
);

    localparam int unsigned AW = $clog2(SAMPLE_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] MaxLoc = AW'(SAMPLE_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPretrig  = 3'd1,
        StArmed    = 3'd2,
        StPosttrig = 3'd3,
        StFilled   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] trigger_loc_q, trigger_loc_d;
    logic [AW-1:0] read_start_q, read_start_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [CW-1:0] post_cnt_q, post_cnt_d;

    // Bus decode
    logic [15:0] offset;
    logic        hit;
    logic [1:0]  reg_sel;
    logic        wr_state;
    logic        arm_req;
    logic        abort_req;
    logic        wr_tloc;
    logic        can_arm;
    logic [15:0] reg_rdata;

    assign offset    = addr_i - BASE_ADDR;
    assign hit       = valid_i && (offset < 16'd4);
    assign reg_sel   = offset[1:0];
    assign wr_state  = hit && rw_i && (reg_sel == 2'd0);
    assign arm_req   = wr_state && (wdata_i == 16'd1);
    assign abort_req = wr_state && (wdata_i == 16'd0);
    assign wr_tloc   = hit && rw_i && (reg_sel == 2'd1);
    assign can_arm   = (state_q == StIdle) || (state_q == StFilled);

    always_comb begin
        reg_rdata = 16'h0000;
        unique case (reg_sel)
            2'd0: reg_rdata = 16'(state_q);
            2'd1: reg_rdata = 16'(trigger_loc_q);
            2'd2: reg_rdata = 16'(read_start_q);
            2'd3: reg_rdata = 16'(trig_addr_q);
            default: reg_rdata = 16'h0000;
        endcase
    end

    // Capture sequencing
    logic [AW-1:0] wr_ptr_inc;
    logic [CW-1:0] post_last;

    assign wr_ptr_inc   = wr_ptr_q + AW'(1);
    // Index of the final post-trigger write; trigger sample itself carries post_cnt 1.
    assign post_last    = CW'(SAMPLE_DEPTH - 1) - CW'(trigger_loc_q);
    assign bram_we      = (state_q == StPretrig) || (state_q == StArmed) ||
                          (state_q == StPosttrig);
    assign bram_addr    = wr_ptr_q;
    assign capture_done = (state_q == StFilled);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        trigger_loc_d = trigger_loc_q;
        read_start_d  = read_start_q;
        trig_addr_d   = trig_addr_q;
        post_cnt_d    = post_cnt_q;

        if (bram_we) begin
            wr_ptr_d = wr_ptr_inc;
        end

        unique case (state_q)
            StPretrig: begin
                // Pre-trigger writes start at address 0, so the pointer doubles as the count.
                if (wr_ptr_q == trigger_loc_q - AW'(1)) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (trig) begin
                    trig_addr_d = wr_ptr_q;
                    post_cnt_d  = CW'(1);
                    if (trigger_loc_q == MaxLoc) begin
                        state_d      = StFilled;
                        read_start_d = wr_ptr_inc;
                    end else begin
                        state_d = StPosttrig;
                    end
                end
            end
            StPosttrig: begin
                post_cnt_d = post_cnt_q + CW'(1);
                if (post_cnt_q == post_last) begin
                    state_d      = StFilled;
                    read_start_d = wr_ptr_inc;
                end
            end
            default: ;
        endcase

        if (arm_req && can_arm) begin
            state_d    = (trigger_loc_q != '0) ? StPretrig : StArmed;
            wr_ptr_d   = '0;
            post_cnt_d = '0;
        end

        // Abort beats any same-cycle trigger or completion bookkeeping.
        if (abort_req) begin
            state_d      = StIdle;
            trig_addr_d  = trig_addr_q;
            read_start_d = read_start_q;
        end

        if (wr_tloc && can_arm) begin
            if (32'(wdata_i) >= SAMPLE_DEPTH) begin
                trigger_loc_d = MaxLoc;
            end else begin
                trigger_loc_d = wdata_i[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            trigger_loc_q <= '0;
            read_start_q  <= '0;
            trig_addr_q   <= '0;
            post_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            trigger_loc_q <= trigger_loc_d;
            read_start_q  <= read_start_d;
            trig_addr_q   <= trig_addr_d;
            post_cnt_q    <= post_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_o  <= 16'h0000;
            wdata_o <= 16'h0000;
            rdata_o <= 16'h0000;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            rdata_o <= (hit && !rw_i) ? reg_rdata : rdata_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
        end
    end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Sequences the logic analyzer's sample BRAM as a circular buffer with a programmable pre-trigger depth.
- Generates the BRAM write strobe and write address for each sample cycle.
- Tracks pre-trigger, armed and post-trigger phases, and reports where the oldest and trigger samples sit once capture completes.
- Sits on the 16-bit register bus chain, so the host arms, aborts and reads back capture geometry.

Parameters:
- BASE_ADDR, 0, first bus address of this block's four registers.
- SAMPLE_DEPTH, 16, number of sample words in BRAM; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- trig  in  1  trigger condition, sampled every clk
- bram_we  out  1  write sample this cycle
- bram_addr  out  $clog2(SAMPLE_DEPTH)  BRAM write address
- capture_done  out  1  high while in FILLED
- addr_i  in  16  bus address
- wdata_i  in  16  bus write data
- rdata_i  in  16  bus read data from upstream
- rw_i  in  1  1=write, 0=read
- valid_i  in  1  bus transaction valid
- addr_o, wdata_o, rdata_o  out  16 each  registered bus passthrough
- rw_o, valid_o  out  1 each  registered bus passthrough

Behaviour:
- Reset, async: state=IDLE, wr_ptr=0, trigger_loc=0, post_cnt=0, read_start=0, trig_addr=0, all outputs 0.
- Bus, 1-cycle latency:
  - All *_o register their *_i every cycle.
  - For valid reads at BASE_ADDR..+3, rdata_o is replaced by the register value, zero-extended.
- Registers:
  - +0 state (R/W).
  - +1 trigger_loc (R/W): pre-trigger sample count.
  - +2 read_start (R): oldest sample address.
  - +3 trig_addr (R): trigger sample address.
- Writes to +0:
  - Write 1 while IDLE or FILLED arms the block.
  - Write 0 in any state aborts to IDLE next cycle.
  - Other values, and arm while capturing, are ignored.
- Writes to +1:
  - Accepted only in IDLE or FILLED.
  - Values ≥SAMPLE_DEPTH clamp to SAMPLE_DEPTH-1.
  - Writes to +2/+3 are ignored.
- States: IDLE=0, PRETRIG=1, ARMED=2, POSTTRIG=3, FILLED=4.
- Arm (cycle 0 write):
  - wr_ptr←0 and post_cnt←0.
  - Next state is PRETRIG if trigger_loc>0, else ARMED.
- bram_we is combinationally high in PRETRIG, ARMED and POSTTRIG, and low otherwise.
- bram_addr=wr_ptr. wr_ptr increments mod SAMPLE_DEPTH on every write cycle.
- PRETRIG:
  - trig is ignored.
  - After trigger_loc writes, go to ARMED.
- ARMED:
  - Writes continue, wrapping freely.
  - When trig=1, that cycle's sample is the trigger sample: trig_addr←wr_ptr, post_cnt←1.
  - If SAMPLE_DEPTH-trigger_loc==1, go to FILLED; else go to POSTTRIG.
- POSTTRIG:
  - post_cnt increments on each write; trig is ignored.
  - The write with post_cnt==SAMPLE_DEPTH-trigger_loc-1 is the last; then go to FILLED.
- Entry to FILLED: read_start←wr_ptr after the final increment; this always equals (trig_addr-trigger_loc) mod SAMPLE_DEPTH.
- FILLED: holds until the host re-arms or aborts.
- Simultaneous events:
  - An arm write and trig in the same cycle: trig is ignored.
  - An abort write in an ARMED cycle with trig=1: abort wins, no trig_addr update.
- Reset mid-capture returns to IDLE immediately; no further writes occur.

Test Plan:
- Reset, then read +0..+3 and BASE_ADDR+4 → rdata_o = 0, 0, 0, 0 and the passthrough value respectively, one cycle after each request.
- SAMPLE_DEPTH=16, trigger_loc=4, arm at cycle 0, trig pulse at cycle 10:
  - writes to addresses 0..3 in cycles 1-4, then 4..9;
  - trig_addr=9, then 11 more writes at 10..15, 0..4;
  - FILLED with read_start=5, trig_addr=9, capture_done=1.
- trigger_loc=0, arm, trig high in the first ARMED cycle → 16 writes at 0..15, read_start=0, trig_addr=0.
- trigger_loc=8, trig held high throughout PRETRIG → trig ignored there; first ARMED cycle (addr 8) becomes trig_addr=8, read_start=0.
- Abort (write 0 to +0) mid-POSTTRIG → state=0 next cycle, bram_we=0; a later re-arm restarts at addr 0.
- Write 20 to +1 in IDLE → reads back 15. Write 3 to +1 while ARMED → ignored, still 15. With trigger_loc=15, trig → FILLED directly from ARMED.
